// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - Load/store unit turning B/H/W accesses into word-wide RAM cycles
// Sub-word stores are read-modify-write; faulted requests skip memory and go straight to RESP.
module load_store_unit #(
  parameter int dataW = 32,
  parameter int addrW = 16
) (
  input  logic             sysCLK,
  input  logic             resetN,
  input  logic             req,
  input  logic             we,
  input  logic [2:0]       funct3,
  input  logic [31:0]      byteAddr,
  input  logic [dataW-1:0] storeData,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [dataW-1:0] loadData,
  output logic [addrW-1:0] memAddr,
  output logic [dataW-1:0] memWData,
  output logic             memWE,
  input  logic [dataW-1:0] memRData
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, ADDR, READ, WRITE, RESP} state_t;

  state_t           state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic [dataW-1:0] sdata_q, sdata_d;
  logic [addrW-1:0] waddr_q, waddr_d;
  logic             fault_q, fault_d;
  logic [dataW-1:0] merge_q, merge_d;
  logic [dataW-1:0] load_q, load_d;

  logic             req_fault;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [dataW-1:0] load_ext;
  logic [dataW-1:0] merged;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^byteAddr[31:addrW+2];

  function automatic logic access_fault(input logic w, input logic [2:0] f3, input logic [1:0] off);
    logic f;
    case (f3)
      F3_B:         f = 1'b0;
      F3_BU:        f = w;
      F3_H:         f = off[0];
      F3_HU:        f = w | off[0];
      F3_W:         f = (off != 2'b00);
      default:      f = 1'b1;
    endcase
    return f;
  endfunction

  assign req_fault = access_fault(we, funct3, byteAddr[1:0]);

  // Little-endian lane extraction and merge against the word just read back.
  always_comb begin
    rd_byte  = memRData[{off_q, 3'b000} +: 8];
    rd_half  = memRData[{off_q[1], 4'b0000} +: 16];
    load_ext = memRData;
    case (f3_q)
      F3_B:    load_ext = {{24{rd_byte[7]}}, rd_byte};
      F3_H:    load_ext = {{16{rd_half[15]}}, rd_half};
      F3_BU:   load_ext = {24'd0, rd_byte};
      F3_HU:   load_ext = {16'd0, rd_half};
      default: load_ext = memRData;
    endcase
    merged = memRData;
    if (f3_q == F3_B) merged[{off_q, 3'b000} +: 8] = sdata_q[7:0];
    else              merged[{off_q[1], 4'b0000} +: 16] = sdata_q[15:0];
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    sdata_d = sdata_q;
    waddr_d = waddr_q;
    fault_d = fault_q;
    merge_d = merge_q;
    load_d  = load_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          f3_d    = funct3;
          off_d   = byteAddr[1:0];
          sdata_d = storeData;
          waddr_d = byteAddr[addrW+1:2];
          fault_d = req_fault;
          state_d = req_fault ? RESP : ADDR;
        end
      end
      ADDR:  state_d = (we_q && f3_q == F3_W) ? RESP : READ;
      READ: begin
        if (!we_q) begin
          load_d  = load_ext;
          state_d = RESP;
        end else begin
          merge_d = merged;
          state_d = WRITE;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysCLK or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      sdata_q <= '0;
      waddr_q <= '0;
      fault_q <= 1'b0;
      merge_q <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      sdata_q <= sdata_d;
      waddr_q <= waddr_d;
      fault_q <= fault_d;
      merge_q <= merge_d;
      load_q  <= load_d;
    end
  end

  // Strobes decode from the registered state only.
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == RESP);
  assign fault    = done & fault_q;
  assign memWE    = (state_q == WRITE) | ((state_q == ADDR) & we_q & (f3_q == F3_W));
  assign memWData = (state_q == WRITE) ? merge_q : sdata_q;
  assign memAddr  = waddr_q;
  assign loadData = load_q;

endmodule
